// File: rtl/lut_conv_pkg.sv
// Shared constants and table helpers for the LUT code converter.
package lut_conv_pkg;

  localparam int unsigned IN_W_DEF  = 3;
  localparam int unsigned OUT_W_DEF = 4;
  localparam int unsigned CNT_W_DEF = 16;

  // Entry i sits at bits [i*OUT_W +: OUT_W]; maps 0..7 -> 1,9,7,6,0,3,1,9.
  localparam logic [31:0] DEFAULT_TABLE = 32'h9130_6791;

  // Upper bounds for the generic entry extractor below.
  localparam int unsigned MAX_OUT_W    = 32;
  localparam int unsigned MAX_TBL_BITS = 4096;
  localparam int unsigned TBL_POS_W    = 12;

  // Extract entry idx of width w from a flat table padded to MAX_TBL_BITS.
  function automatic logic [MAX_OUT_W-1:0] table_entry(
    input logic [MAX_TBL_BITS-1:0] flat,
    input int unsigned             idx,
    input int unsigned             w
  );
    logic [MAX_OUT_W-1:0] e;
    logic [TBL_POS_W-1:0] pos;
    e = '0;
    for (int unsigned b = 0; b < MAX_OUT_W; b++) begin
      if (b < w) begin
        pos = TBL_POS_W'(idx * w + b);
        e   = e | (MAX_OUT_W'(flat[pos]) << b);
      end
    end
    return e;
  endfunction

endpackage

// File: rtl/lut_code_converter_table.sv
// DEPTH x OUT_W mapping table: synchronous write, asynchronous read,
// reloaded from INIT_TABLE on reset (reset beats a same-cycle write).
module lut_table
  import lut_conv_pkg::*;
#(
  parameter int unsigned                      IN_W       = IN_W_DEF,
  parameter int unsigned                      OUT_W      = OUT_W_DEF,
  parameter logic [(2**IN_W)*OUT_W-1:0]       INIT_TABLE = DEFAULT_TABLE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [IN_W-1:0]  waddr,
  input  logic [OUT_W-1:0] wdata,
  input  logic [IN_W-1:0]  raddr,
  output logic [OUT_W-1:0] rdata
);

  localparam int unsigned DEPTH = 2**IN_W;
  localparam logic [MAX_TBL_BITS-1:0] INIT_PAD = MAX_TBL_BITS'(INIT_TABLE);

  logic [OUT_W-1:0] mem_q [DEPTH];
  logic [OUT_W-1:0] mem_d [DEPTH];

  // Next table contents: apply the single write port.
  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  // Table storage with reset reload.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[IN_W'(i)] <= OUT_W'(table_entry(INIT_PAD, i, OUT_W));
      end
    end else begin
      mem_q <= mem_d;
    end
  end

  // Read reflects the pre-edge contents, giving read-before-write behaviour.
  assign rdata = mem_q[raddr];

endmodule

// File: rtl/lut_code_converter.sv
// Two-stage valid/ready table-driven code converter with a saturating
// count of completed output transfers.
module lut_code_converter
  import lut_conv_pkg::*;
#(
  parameter int unsigned                IN_W       = IN_W_DEF,
  parameter int unsigned                OUT_W      = OUT_W_DEF,
  parameter logic [(2**IN_W)*OUT_W-1:0] INIT_TABLE = DEFAULT_TABLE,
  parameter int unsigned                CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_code,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_code,
  input  logic             cfg_we,
  input  logic [IN_W-1:0]  cfg_addr,
  input  logic [OUT_W-1:0] cfg_data,
  output logic [CNT_W-1:0] conv_count,
  output logic             count_sat
);

  logic             a_valid_q, a_valid_d;
  logic [IN_W-1:0]  a_code_q,  a_code_d;
  logic             b_valid_q, b_valid_d;
  logic [OUT_W-1:0] b_code_q,  b_code_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             sat_q,     sat_d;
  logic [OUT_W-1:0] lut_rdata;
  logic             b_adv, a_adv, accept, xfer;

  lut_table #(
    .IN_W       (IN_W),
    .OUT_W      (OUT_W),
    .INIT_TABLE (INIT_TABLE)
  ) u_table (
    .clk   (clk),
    .rst   (rst),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (a_code_q),
    .rdata (lut_rdata)
  );

  // Handshake: each stage moves when the one after it can take data.
  always_comb begin
    b_adv   = !b_valid_q || m_ready;
    a_adv   = a_valid_q && b_adv;
    s_ready = !a_valid_q || b_adv;
    accept  = s_valid && s_ready;
    xfer    = b_valid_q && m_ready;
  end

  // Next-state for both pipeline stages; B holds its code while stalled.
  always_comb begin
    a_valid_d = a_valid_q;
    a_code_d  = a_code_q;
    b_valid_d = b_valid_q;
    b_code_d  = b_code_q;
    if (accept) begin
      a_valid_d = 1'b1;
      a_code_d  = s_code;
    end else if (a_adv) begin
      a_valid_d = 1'b0;
    end
    if (b_adv) begin
      b_valid_d = a_valid_q;
      if (a_valid_q) b_code_d = lut_rdata;
    end
  end

  // Saturating transfer counter and its sticky flag.
  always_comb begin
    cnt_d = cnt_q;
    if (xfer && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
    sat_d = (cnt_d == '1);
  end

  // Pipeline and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid_q <= 1'b0;
      a_code_q  <= '0;
      b_valid_q <= 1'b0;
      b_code_q  <= '0;
      cnt_q     <= '0;
      sat_q     <= 1'b0;
    end else begin
      a_valid_q <= a_valid_d;
      a_code_q  <= a_code_d;
      b_valid_q <= b_valid_d;
      b_code_q  <= b_code_d;
      cnt_q     <= cnt_d;
      sat_q     <= sat_d;
    end
  end

  assign m_valid    = b_valid_q;
  assign m_code     = b_code_q;
  assign conv_count = cnt_q;
  assign count_sat  = sat_q;

endmodule

// File: tb/tb_lut_code_converter.sv
// Scoreboard bench: default build, a CNT_W=3 build sharing its stimulus,
// and an IN_W=4/OUT_W=8 identity build with random backpressure.
module tb_lut_code_converter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Default build signals (also drive the CNT_W=3 build).
  logic        rst = 1'b1;
  logic        s_valid = 1'b0, s_ready, m_valid, m_ready = 1'b1, count_sat;
  logic [2:0]  s_code = '0, cfg_addr = '0;
  logic [3:0]  m_code, cfg_data = '0;
  logic        cfg_we = 1'b0;
  logic [15:0] conv_count;

  logic        c_s_ready, c_m_valid, c_sat;
  logic [3:0]  c_m_code;
  logic [2:0]  c_count;

  // Wide identity build signals.
  logic        w_s_valid = 1'b0, w_s_ready, w_m_valid, w_m_ready = 1'b1, w_sat;
  logic [3:0]  w_s_code = '0;
  logic [7:0]  w_m_code;
  logic [15:0] w_count;

  lut_code_converter dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_code(s_code),
    .m_valid(m_valid), .m_ready(m_ready), .m_code(m_code),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .conv_count(conv_count), .count_sat(count_sat)
  );

  lut_code_converter #(.CNT_W(3)) dut_c (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(c_s_ready), .s_code(s_code),
    .m_valid(c_m_valid), .m_ready(m_ready), .m_code(c_m_code),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .conv_count(c_count), .count_sat(c_sat)
  );

  lut_code_converter #(
    .IN_W(4), .OUT_W(8),
    .INIT_TABLE(128'h0F0E_0D0C_0B0A_0908_0706_0504_0302_0100)
  ) dut_w (
    .clk(clk), .rst(rst), .s_valid(w_s_valid), .s_ready(w_s_ready), .s_code(w_s_code),
    .m_valid(w_m_valid), .m_ready(w_m_ready), .m_code(w_m_code),
    .cfg_we(1'b0), .cfg_addr(4'h0), .cfg_data(8'h00),
    .conv_count(w_count), .count_sat(w_sat)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboards
  logic [3:0]  exp_q[$];
  logic [7:0]  w_exp_q[$];
  int unsigned out_cyc[$];

  // Main monitor: in-order comparison plus hold-stable check while stalled.
  logic       prev_v = 1'b0, prev_r = 1'b0, prev_rst = 1'b1;
  logic [3:0] prev_code = '0;
  always @(negedge clk) begin
    if (prev_v && !prev_r && !prev_rst) begin
      chk("stall_valid_held", m_valid, 1);
      chk("stall_code_held", m_code, prev_code);
    end
    if (m_valid && m_ready && !rst) begin
      out_cyc.push_back(cyc);
      if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
      else chk("m_code", m_code, exp_q.pop_front());
    end
    prev_v = m_valid; prev_r = m_ready; prev_rst = rst; prev_code = m_code;
  end

  // CNT_W=3 counter model: count transfers, saturating at 7.
  int unsigned c_n = 0;
  logic        c_pend_x = 1'b0, c_pend_rst = 1'b1;
  always @(negedge clk) begin
    if (c_pend_rst) c_n = 0;
    else if (c_pend_x) c_n++;
    if (!c_pend_rst && c_pend_x) begin
      chk("sat_count", c_count, (c_n > 7) ? 7 : c_n);
      chk("sat_flag", c_sat, (c_n >= 7) ? 1 : 0);
    end
    c_pend_x = c_m_valid && m_ready;
    c_pend_rst = rst;
  end

  // Wide build monitor.
  always @(negedge clk) begin
    if (w_m_valid && w_m_ready && !rst) begin
      if (w_exp_q.size() == 0) chk("w_unexpected_output", 1, 0);
      else chk("w_m_code", w_m_code, w_exp_q.pop_front());
    end
  end

  // Offer one code, wait (bounded) for acceptance, optionally score it.
  task automatic send(input logic [2:0] c, input logic [3:0] e, input bit score);
    int unsigned n = 0;
    s_valid = 1'b1; s_code = c;
    forever begin
      @(negedge clk);
      if (s_ready) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", 0, 1);
        s_valid = 1'b0;
        return;
      end
    end
    if (score) exp_q.push_back(e);
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic w_send(input logic [3:0] c);
    int unsigned n = 0;
    w_s_valid = 1'b1; w_s_code = c;
    forever begin
      @(negedge clk);
      if (w_s_ready) break;
      n++;
      if (n > 200) begin
        chk("w_send_timeout", 0, 1);
        w_s_valid = 1'b0;
        return;
      end
    end
    w_exp_q.push_back({4'h0, c});
    @(posedge clk); #1;
    w_s_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (exp_q.size() != 0 || w_exp_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 300) begin
        chk("drain_timeout", 0, 1);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic one_cycle_cfg(input logic [2:0] a, input logic [3:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  logic [3:0] tbl [8] = '{4'h1, 4'h9, 4'h7, 4'h6, 4'h0, 4'h3, 4'h1, 4'h9};
  bit w_run = 1'b0;

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_code", m_code, 0);
    chk("rst_count", conv_count, 0);
    chk("rst_sat", count_sat, 0);
    chk("rst_s_ready", s_ready, 1);
    @(posedge clk); #1;

    // 1: back-to-back 0..7, latency and one output per cycle.
    out_cyc.delete();
    send(3'd0, tbl[0], 1'b1);
    chk("lat_not_yet", m_valid, 0);
    send(3'd1, tbl[1], 1'b1);
    chk("lat_valid", m_valid, 1);
    chk("lat_code", m_code, 4'h1);
    for (int i = 2; i < 8; i++) send(3'(i), tbl[i], 1'b1);
    drain();
    chk("t1_count", conv_count, 8);
    chk("t1_outputs", out_cyc.size(), 8);
    if (out_cyc.size() == 8) chk("t1_no_gaps", out_cyc[7] - out_cyc[0], 7);

    // 2: backpressure, two accepted then s_ready drops, output held.
    m_ready = 1'b0;
    out_cyc.delete();
    send(3'd2, 4'h7, 1'b1);
    send(3'd3, 4'h6, 1'b1);
    s_valid = 1'b1; s_code = 3'd5;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_s_ready_low", s_ready, 0);
      chk("t2_held_code", m_code, 4'h7);
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    send(3'd5, 4'h3, 1'b1);
    drain();
    chk("t2_outputs", out_cyc.size(), 3);
    if (out_cyc.size() == 3) chk("t2_no_gaps", out_cyc[2] - out_cyc[0], 2);
    chk("t2_count", conv_count, 11);

    // 3: table overwrite and read-before-write.
    one_cycle_cfg(3'd4, 4'hF);
    send(3'd4, 4'hF, 1'b1);
    send(3'd2, 4'h7, 1'b1);
    one_cycle_cfg(3'd2, 4'hA);
    send(3'd2, 4'hA, 1'b1);
    drain();
    chk("t3_count", conv_count, 14);
    chk("sat_build_flag", c_sat, 1);

    // 4: reset with codes in flight and a same-cycle cfg write.
    m_ready = 1'b0;
    send(3'd1, 4'h0, 1'b0);
    send(3'd3, 4'h0, 1'b0);
    rst = 1'b1;
    cfg_we = 1'b1; cfg_addr = 3'd4; cfg_data = 4'h5;
    @(posedge clk); #1;
    rst = 1'b0; cfg_we = 1'b0;
    chk("t4_m_valid", m_valid, 0);
    chk("t4_m_code", m_code, 0);
    chk("t4_count", conv_count, 0);
    chk("t4_sat", count_sat, 0);
    chk("t4_sat_build_count", c_count, 0);
    m_ready = 1'b1;
    send(3'd4, 4'h0, 1'b1);
    send(3'd2, 4'h7, 1'b1);
    drain();
    chk("t4_count_after", conv_count, 2);

    // 6: wide identity build under random backpressure.
    w_run = 1'b1;
    fork
      begin
        while (w_run) begin
          @(posedge clk); #1;
          w_m_ready = 1'($urandom_range(0, 1));
        end
        w_m_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 16; i++) w_send(4'(i));
        drain();
        w_run = 1'b0;
      end
    join
    @(posedge clk); #1;
    chk("t6_count", w_count, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
